// File: rtl/board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : board_io_ctrl_debounce / board_io_ctrl
// Description : Board I/O and execution controller for the RV32I core.
//               Generates the core clock-enable (run / single-step / halt),
//               synchronises and debounces switches and the step button, and
//               exposes LED, SW, CTRL and CYCLE registers on a pipelined
//               memory-mapped slave port (ack one cycle after request).
// Ports       : clk, rst            - system clock, synchronous active-high reset
//               sw_in, btn_in       - raw asynchronous switches / step button
//               led_out             - LED register
//               core_ce             - one-cycle core clock-enable pulse
//               bus_req/we/addr/be/wdata - slave request (sampled every cycle)
//               bus_ack, bus_rdata  - completion and read data (0 when idle)
// Revision    : 1.0 - initial release
// ============================================================================

module board_io_ctrl_debounce #(
   parameter int WIDTH      = 16,
   parameter int DEB_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stable
);

   localparam int            CW          = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] C_CNT_MAX   = CW'(DEB_CYCLES - 1);

   logic [WIDTH-1:0] r_last;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_stable;

   // Any change restarts the window; once the counter saturates the held
   // value is copied to the output every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last   <= '0;
         r_cnt    <= '0;
         r_stable <= '0;
      end else if (din != r_last) begin
         r_last <= din;
         r_cnt  <= '0;
      end else if (r_cnt == C_CNT_MAX) begin
         r_stable <= r_last;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign stable = r_stable;

endmodule

module board_io_ctrl #(
   parameter int DIV_LOG2   = 15,
   parameter int DEB_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] sw_in,
   input  logic        btn_in,
   output logic [15:0] led_out,
   output logic        core_ce,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [3:0]  bus_be,
   input  logic [31:0] bus_wdata,
   output logic        bus_ack,
   output logic [31:0] bus_rdata
);

   localparam logic [1:0] C_ADDR_LED   = 2'd0;
   localparam logic [1:0] C_ADDR_SW    = 2'd1;
   localparam logic [1:0] C_ADDR_CTRL  = 2'd2;
   localparam logic [1:0] C_ADDR_CYCLE = 2'd3;

   // ---------------------------------------------------------------------
   // Two-flop synchronisers
   // ---------------------------------------------------------------------
   logic [15:0] r_sw_meta;
   logic [15:0] r_sw_sync;
   logic        r_btn_meta;
   logic        r_btn_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sw_meta  <= '0;
         r_sw_sync  <= '0;
         r_btn_meta <= 1'b0;
         r_btn_sync <= 1'b0;
      end else begin
         r_sw_meta  <= sw_in;
         r_sw_sync  <= r_sw_meta;
         r_btn_meta <= btn_in;
         r_btn_sync <= r_btn_meta;
      end
   end

   // ---------------------------------------------------------------------
   // Debounce
   // ---------------------------------------------------------------------
   logic [15:0] w_sw_stable;
   logic        w_btn_stable;

   board_io_ctrl_debounce #(
      .WIDTH      (16),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_sw_deb (
      .clk    (clk),
      .rst    (rst),
      .din    (r_sw_sync),
      .stable (w_sw_stable)
   );

   board_io_ctrl_debounce #(
      .WIDTH      (1),
      .DEB_CYCLES (DEB_CYCLES)
   ) u_btn_deb (
      .clk    (clk),
      .rst    (rst),
      .din    (r_btn_sync),
      .stable (w_btn_stable)
   );

   // ---------------------------------------------------------------------
   // Bus decode
   // ---------------------------------------------------------------------
   logic w_wr;
   logic w_led_wr;
   logic w_ctrl_wr;
   logic w_cycle_clr;
   logic w_unused;

   assign w_wr        = bus_req & bus_we;
   assign w_led_wr    = w_wr && (bus_addr[3:2] == C_ADDR_LED);
   assign w_ctrl_wr   = w_wr && (bus_addr[3:2] == C_ADDR_CTRL);
   assign w_cycle_clr = w_wr && (bus_addr[3:2] == C_ADDR_CYCLE) && (|bus_be);
   assign w_unused    = ^{bus_addr[1:0], bus_wdata[31:16]};

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   logic [15:0]         r_led;
   logic [1:0]          r_ctrl;      // [0] STEP, [1] HALT
   logic [31:0]         r_cycle;
   logic [DIV_LOG2-1:0] r_div;
   logic                r_core_ce;
   logic                r_btn_stable_q;
   logic                r_ack;
   logic [31:0]         r_rdata;
   logic [31:0]         w_rd_mux;

   // Reads see register state before this cycle's write takes effect.
   always_comb begin
      w_rd_mux = '0;
      case (bus_addr[3:2])
         C_ADDR_LED:   w_rd_mux = {16'h0000, r_led};
         C_ADDR_SW:    w_rd_mux = {16'h0000, w_sw_stable};
         C_ADDR_CTRL:  w_rd_mux = {30'h0, r_ctrl};
         C_ADDR_CYCLE: w_rd_mux = r_cycle;
         default:      w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_led   <= '0;
         r_ctrl  <= '0;
      end else begin
         r_ack   <= bus_req;
         r_rdata <= (bus_req && !bus_we) ? w_rd_mux : 32'h0;
         if (w_led_wr && bus_be[0]) r_led[7:0]  <= bus_wdata[7:0];
         if (w_led_wr && bus_be[1]) r_led[15:8] <= bus_wdata[15:8];
         if (w_ctrl_wr && bus_be[0]) r_ctrl <= bus_wdata[1:0];
      end
   end

   // ---------------------------------------------------------------------
   // core_ce generation: HALT > STEP > run. The button edge detector runs
   // in every mode so a press during HALT is consumed rather than queued.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_core_ce      <= 1'b0;
         r_div          <= '0;
         r_btn_stable_q <= 1'b0;
      end else begin
         r_btn_stable_q <= w_btn_stable;

         if (r_ctrl[1]) begin
            r_core_ce <= 1'b0;
         end else if (r_ctrl[0]) begin
            r_core_ce <= w_btn_stable & ~r_btn_stable_q;
         end else begin
            r_core_ce <= &r_div;
         end

         if (w_ctrl_wr) begin
            r_div <= '0;
         end else if (!r_ctrl[1] && !r_ctrl[0]) begin
            r_div <= r_div + DIV_LOG2'(1);
         end
      end
   end

   // Clearing write has priority over a coincident increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cycle <= '0;
      end else if (w_cycle_clr) begin
         r_cycle <= '0;
      end else if (r_core_ce) begin
         r_cycle <= r_cycle + 32'd1;
      end
   end

   assign led_out   = r_led;
   assign core_ce   = r_core_ce;
   assign bus_ack   = r_ack;
   assign bus_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_board_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_io_ctrl
// Description : Directed self-checking bench for board_io_ctrl
//               (DIV_LOG2=3, DEB_CYCLES=4). Inputs change on the falling
//               edge, outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_board_io_ctrl;

   localparam int DIV_LOG2   = 3;
   localparam int DEB_CYCLES = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw_in;
   logic        btn_in;
   logic [15:0] led_out;
   logic        core_ce;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;    // number of rising edges so far
   int n_ce  = 0;    // number of core_ce pulses observed

   logic [31:0] d;
   logic        a;
   int          at, kp, snap, rel, w, prev;

   board_io_ctrl #(
      .DIV_LOG2   (DIV_LOG2),
      .DEB_CYCLES (DEB_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_in     (sw_in),
      .btn_in    (btn_in),
      .led_out   (led_out),
      .core_ce   (core_ce),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_be    (bus_be),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (core_ce === 1'b1) n_ce <= n_ce + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] wd);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_be = be; bus_wdata = wd;
      @(negedge clk);
      bus_req = 1'b0; bus_we = 1'b0; bus_be = 4'h0; bus_wdata = 32'h0;
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [31:0] data, output logic ack);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = addr; bus_be = 4'h0;
      @(negedge clk);
      data = bus_rdata;
      ack  = bus_ack;
      bus_req = 1'b0;
   endtask

   // Returns the edge number of the next core_ce pulse, or -1 on timeout.
   task automatic wait_ce(input int bound, output int edge_at);
      edge_at = -1;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (core_ce === 1'b1) begin
            edge_at = cyc;
            break;
         end
      end
   endtask

   initial begin
      // ---------------- Reset ----------------
      rst = 1'b1; sw_in = 16'hFFFF; btn_in = 1'b0;
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = 4'h8; bus_be = 4'h0; bus_wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_led", {16'h0, led_out}, 32'h0);
         check("rst_ce",  {31'h0, core_ce}, 32'h0);
         check("rst_ack", {31'h0, bus_ack}, 32'h0);
      end
      rst = 1'b0; bus_req = 1'b0;
      rel = cyc;
      bus_read(4'h8, d, a);
      check("rst_ctrl_ack", {31'h0, a}, 32'h1);
      check("rst_ctrl", d, 32'h0);
      bus_read(4'hC, d, a);
      check("rst_cycle", d, 32'h0);

      // ---------------- Run mode ----------------
      wait_ce(20, at);
      check("run_first", 32'(at), 32'(rel + 8));
      @(negedge clk);
      check("run_width", {31'h0, core_ce}, 32'h0);
      prev = rel + 8;
      for (int i = 0; i < 4; i++) begin
         wait_ce(20, at);
         check("run_period", 32'(at), 32'(prev + 8));
         prev = prev + 8;
      end
      @(negedge clk);
      bus_read(4'hC, d, a);
      check("run_cycle5", d, 32'd5);
      @(negedge clk);
      bus_write(4'h8, 4'h1, 32'h0);
      w = cyc;
      wait_ce(20, at);
      check("run_ctrl_restart", 32'(at), 32'(w + 8));

      // ---------------- LED writes (halted) ----------------
      bus_write(4'h8, 4'h1, 32'h2);
      snap = n_ce;
      repeat (20) @(negedge clk);
      check("halt_no_ce", 32'(n_ce), 32'(snap));
      bus_write(4'h0, 4'b0011, 32'h0000_A5C3);
      check("led_wr_ack", {31'h0, bus_ack}, 32'h1);
      check("led_a5c3", {16'h0, led_out}, 32'h0000_A5C3);
      bus_write(4'h0, 4'b0010, 32'h0000_1200);
      check("led_12c3", {16'h0, led_out}, 32'h0000_12C3);
      bus_read(4'h0, d, a);
      check("b2b_ack0", {31'h0, a}, 32'h1);
      check("b2b_rd0", d, 32'h0000_12C3);
      bus_read(4'h0, d, a);
      check("b2b_ack1", {31'h0, a}, 32'h1);
      check("b2b_rd1", d, 32'h0000_12C3);
      @(negedge clk);
      check("idle_ack", {31'h0, bus_ack}, 32'h0);
      check("idle_rdata", bus_rdata, 32'h0);

      // ---------------- Switch debounce ----------------
      sw_in = 16'h0000;
      repeat (20) @(negedge clk);
      bus_read(4'h4, d, a);
      check("sw_zero", d, 32'h0);
      sw_in = 16'h00F0;
      for (int i = 0; i < 3; i++) begin
         bus_read(4'h4, d, a);
         check("sw_glitch_hi", d, 32'h0);
      end
      sw_in = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         bus_read(4'h4, d, a);
         check("sw_glitch_lo", d, 32'h0);
      end
      sw_in = 16'h00F0;
      for (int i = 0; i < 8; i++) begin
         bus_read(4'h4, d, a);
         check("sw_settle", d, (i < 7) ? 32'h0 : 32'h0000_00F0);
      end
      bus_write(4'h4, 4'hF, 32'hFFFF_FFFF);
      check("sw_wr_ack", {31'h0, bus_ack}, 32'h1);
      bus_read(4'h4, d, a);
      check("sw_ro", d, 32'h0000_00F0);

      // ---------------- Step mode ----------------
      bus_write(4'h8, 4'h1, 32'h1);
      repeat (5) @(negedge clk);
      snap = n_ce;
      btn_in = 1'b1;
      kp = cyc;
      wait_ce(20, at);
      check("step_latency", 32'(at), 32'(kp + 8));
      repeat (2) @(negedge clk);
      btn_in = 1'b0;
      repeat (30) @(negedge clk);
      check("step_one_pulse", 32'(n_ce - snap), 32'd1);

      bus_write(4'h8, 4'h1, 32'h3);
      snap = n_ce;
      btn_in = 1'b1;
      repeat (12) @(negedge clk);
      bus_write(4'h8, 4'h1, 32'h1);
      repeat (5) @(negedge clk);
      btn_in = 1'b0;
      repeat (20) @(negedge clk);
      check("halt_press_dropped", 32'(n_ce - snap), 32'd0);

      // ---------------- CYCLE wrap and clear ----------------
      force dut.r_cycle = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_cycle;
      bus_read(4'hC, d, a);
      check("cycle_preload", d, 32'hFFFF_FFFF);
      btn_in = 1'b1;
      kp = cyc;
      wait_ce(20, at);
      check("wrap_pulse", 32'(at), 32'(kp + 8));
      @(negedge clk);
      bus_read(4'hC, d, a);
      check("cycle_wrap", d, 32'h0);
      btn_in = 1'b0;
      repeat (20) @(negedge clk);

      btn_in = 1'b1;
      repeat (8) @(negedge clk);
      check("coinc_ce", {31'h0, core_ce}, 32'h1);
      bus_write(4'hC, 4'b0100, 32'h0);
      bus_read(4'hC, d, a);
      check("cycle_clear_wins", d, 32'h0);
      btn_in = 1'b0;
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
